// File: rtl/hs_tx_byte_sequencer.sv
// HS transmit byte sequencer for one D-PHY data lane.
// Frames each PPI burst as HS-zero, SoT sync byte, payload, HS-trail.
module hs_tx_byte_sequencer #(
    parameter int                 WIDTH        = 8,
    parameter int                 ZERO_CYCLES  = 4,
    parameter int                 TRAIL_CYCLES = 3,
    parameter logic [WIDTH-1:0]   SYNC_BYTE    = 8'hB8
) (
    input  logic             TxByteClk,
    input  logic             TxRst,
    input  logic             TxRequestHS,
    input  logic [WIDTH-1:0] TxDataHS,
    output logic             TxReadyHS,
    output logic [WIDTH-1:0] ser_data,
    output logic             serializer_enable,
    output logic             hs_active,
    output logic             busy,
    output logic [2:0]       state_dbg
);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_ZERO  = 3'd1,
        ST_SYNC  = 3'd2,
        ST_DATA  = 3'd3,
        ST_TRAIL = 3'd4,
        ST_EXIT  = 3'd5
    } state_t;

    localparam int MAX_CYC = (ZERO_CYCLES > TRAIL_CYCLES) ? ZERO_CYCLES : TRAIL_CYCLES;
    localparam int CW      = $clog2(MAX_CYC) + 1;
    localparam logic [CW-1:0] ZERO_LAST  = CW'(ZERO_CYCLES - 1);
    localparam logic [CW-1:0] TRAIL_LAST = CW'(TRAIL_CYCLES - 1);

    state_t           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             last_bit_q, last_bit_d;
    logic             ready_q, ready_d;
    logic [WIDTH-1:0] data_q, data_d;
    logic             en_q, en_d;
    logic             hs_q, hs_d;
    logic             busy_q, busy_d;
    logic [WIDTH-1:0] trail_byte;

    assign trail_byte = {WIDTH{~last_bit_q}};

    // Each state's byte lands on ser_data one cycle after the state is held, which
    // lines the sync byte up with the first DATA cycle so payload follows without a gap.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        last_bit_d = last_bit_q;
        ready_d    = 1'b0;
        data_d     = '0;
        en_d       = 1'b0;
        hs_d       = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (TxRequestHS) begin
                    state_d = ST_ZERO;
                    cnt_d   = '0;
                end
            end
            ST_ZERO: begin
                en_d = 1'b1;
                hs_d = 1'b1;
                if (cnt_q == ZERO_LAST) begin
                    state_d = ST_SYNC;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            ST_SYNC: begin
                en_d   = 1'b1;
                hs_d   = 1'b1;
                data_d = SYNC_BYTE;
                cnt_d  = '0;
                if (TxRequestHS) begin
                    state_d = ST_DATA;
                    ready_d = 1'b1;
                end else begin
                    state_d    = ST_TRAIL;
                    last_bit_d = SYNC_BYTE[WIDTH-1];
                end
            end
            ST_DATA: begin
                en_d = 1'b1;
                hs_d = 1'b1;
                if (TxRequestHS) begin
                    data_d     = TxDataHS;
                    last_bit_d = TxDataHS[WIDTH-1];
                    ready_d    = 1'b1;
                end else begin
                    // The drop cycle already emits the first trail byte.
                    data_d = trail_byte;
                    if (TRAIL_CYCLES == 1) begin
                        state_d = ST_EXIT;
                        cnt_d   = '0;
                    end else begin
                        state_d = ST_TRAIL;
                        cnt_d   = CW'(1);
                    end
                end
            end
            ST_TRAIL: begin
                en_d   = 1'b1;
                hs_d   = 1'b1;
                data_d = trail_byte;
                if (cnt_q == TRAIL_LAST) begin
                    state_d = ST_EXIT;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            ST_EXIT: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
        endcase
        busy_d = (state_d != ST_IDLE);
    end

    always_ff @(posedge TxByteClk or posedge TxRst) begin
        if (TxRst) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            last_bit_q <= 1'b0;
            ready_q    <= 1'b0;
            data_q     <= '0;
            en_q       <= 1'b0;
            hs_q       <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            last_bit_q <= last_bit_d;
            ready_q    <= ready_d;
            data_q     <= data_d;
            en_q       <= en_d;
            hs_q       <= hs_d;
            busy_q     <= busy_d;
        end
    end

    assign TxReadyHS         = ready_q;
    assign ser_data          = data_q;
    assign serializer_enable = en_q;
    assign hs_active         = hs_q;
    assign busy              = busy_q;
    assign state_dbg         = state_q;

endmodule

// File: tb/tb_hs_tx_byte_sequencer.sv
// Bench for hs_tx_byte_sequencer: two instances (4/3 and 1/1 zero/trail lengths),
// random and directed bursts, expected lane bytes queued per burst and checked by a monitor.
module tb_hs_tx_byte_sequencer;

    localparam logic [7:0] SYNC = 8'hB8;
    localparam logic [2:0] ST_EXIT_CODE = 3'd5;

    logic       clk = 1'b0;
    logic       rst;
    logic       req  [2];
    logic [7:0] din  [2];
    logic       rdy  [2];
    logic [7:0] ser  [2];
    logic       en   [2];
    logic       hs   [2];
    logic       bsy  [2];
    logic [2:0] st   [2];

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    bit mon_on = 1'b0;
    logic [7:0] exp_q0[$];
    logic [7:0] exp_q1[$];
    logic [7:0] pay_q[$];
    int req_t     [2];
    bit lat_armed [2];
    int burst_pos [2];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    hs_tx_byte_sequencer #(.WIDTH(8), .ZERO_CYCLES(4), .TRAIL_CYCLES(3), .SYNC_BYTE(8'hB8)) dut_a (
        .TxByteClk(clk), .TxRst(rst), .TxRequestHS(req[0]), .TxDataHS(din[0]),
        .TxReadyHS(rdy[0]), .ser_data(ser[0]), .serializer_enable(en[0]),
        .hs_active(hs[0]), .busy(bsy[0]), .state_dbg(st[0])
    );

    hs_tx_byte_sequencer #(.WIDTH(8), .ZERO_CYCLES(1), .TRAIL_CYCLES(1), .SYNC_BYTE(8'hB8)) dut_b (
        .TxByteClk(clk), .TxRst(rst), .TxRequestHS(req[1]), .TxDataHS(din[1]),
        .TxReadyHS(rdy[1]), .ser_data(ser[1]), .serializer_enable(en[1]),
        .hs_active(hs[1]), .busy(bsy[1]), .state_dbg(st[1])
    );

    function automatic int zc(input int i);
        return (i == 0) ? 4 : 1;
    endfunction

    function automatic int tc(input int i);
        return (i == 0) ? 3 : 1;
    endfunction

    task automatic fail_chk(input bit ok, input string name, input int act, input int exp);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic push_exp(input int i, input logic [7:0] v);
        if (i == 0) exp_q0.push_back(v);
        else        exp_q1.push_back(v);
    endtask

    // Monitor: every enabled lane cycle must match the next queued byte.
    task automatic mon_step(input int i);
        logic [7:0] e;
        bit         empty;
        fail_chk(!(rdy[i] && !bsy[i]), $sformatf("ready_outside_burst%0d", i), rdy[i], 0);
        if (en[i]) begin
            empty = (i == 0) ? (exp_q0.size() == 0) : (exp_q1.size() == 0);
            if (empty) begin
                fail_chk(1'b0, $sformatf("unexpected_enable%0d", i), ser[i], 0);
            end else begin
                e = (i == 0) ? exp_q0.pop_front() : exp_q1.pop_front();
                fail_chk(ser[i] === e, $sformatf("ser_data%0d pos%0d", i, burst_pos[i]), ser[i], e);
                fail_chk(hs[i] === 1'b1, $sformatf("hs_active%0d", i), hs[i], 1);
            end
            if (burst_pos[i] == zc(i) && lat_armed[i]) begin
                fail_chk(cyc - req_t[i] == zc(i) + 2, $sformatf("sync_latency%0d", i),
                         cyc - req_t[i], zc(i) + 2);
                lat_armed[i] = 1'b0;
            end
            burst_pos[i]++;
        end else begin
            burst_pos[i] = 0;
            if (hs[i] !== 1'b0) fail_chk(1'b0, $sformatf("hs_without_enable%0d", i), hs[i], 0);
        end
    endtask

    always @(negedge clk) begin
        if (mon_on && !rst) begin
            for (int i = 0; i < 2; i++) mon_step(i);
        end
    end

    task automatic wait_idle(input int i);
        int b = 0;
        while (bsy[i] !== 1'b0 && b < 400) begin
            @(negedge clk);
            b++;
        end
        if (b >= 400) fail_chk(1'b0, $sformatf("idle_timeout%0d", i), bsy[i], 0);
    endtask

    // Sends pay_q as one burst; from_exit raises the request during EXIT of the previous burst.
    task automatic send_burst(input int i, input bit from_exit);
        int         n;
        int         idx;
        int         b;
        bit         acc;
        bit         saw_ready;
        logic [7:0] tr;
        n = pay_q.size();
        for (int z = 0; z < zc(i); z++) push_exp(i, 8'h00);
        push_exp(i, SYNC);
        for (int k = 0; k < n; k++) push_exp(i, pay_q[k]);
        tr = (n == 0) ? 8'h00 : (pay_q[n-1][7] ? 8'h00 : 8'hFF);
        for (int t = 0; t < tc(i); t++) push_exp(i, tr);

        if (from_exit) begin
            b = 0;
            while (st[i] !== ST_EXIT_CODE && b < 400) begin
                @(negedge clk);
                b++;
            end
            if (b >= 400) fail_chk(1'b0, $sformatf("exit_timeout%0d", i), st[i], ST_EXIT_CODE);
            req_t[i] = cyc + 1;
        end else begin
            wait_idle(i);
            req_t[i] = cyc;
        end
        lat_armed[i] = 1'b1;
        req[i] = 1'b1;
        din[i] = (n > 0) ? pay_q[0] : 8'($urandom_range(0, 255));

        if (n == 0) begin
            @(negedge clk);
            req[i] = 1'b0;
            saw_ready = 1'b0;
            for (int c = 0; c < zc(i) + tc(i) + 4; c++) begin
                if (rdy[i]) saw_ready = 1'b1;
                @(negedge clk);
            end
            fail_chk(!saw_ready, $sformatf("zero_len_ready%0d", i), saw_ready, 0);
        end else begin
            idx = 0;
            b = 0;
            while (idx < n && b < 2000) begin
                acc = rdy[i];
                @(negedge clk);
                b++;
                if (acc) begin
                    idx++;
                    if (idx < n) din[i] = pay_q[idx];
                end
            end
            req[i] = 1'b0;
            din[i] = 8'($urandom_range(0, 255));
            if (idx < n) fail_chk(1'b0, $sformatf("accept_timeout%0d", i), idx, n);
        end
    endtask

    task automatic random_burst(input int i, input int max_len);
        int n;
        n = $urandom_range(0, max_len);
        pay_q.delete();
        for (int k = 0; k < n; k++) pay_q.push_back(8'($urandom_range(0, 255)));
        send_burst(i, 1'b0);
        repeat ($urandom_range(0, 3)) @(negedge clk);
    endtask

    initial begin
        int b;
        rst = 1'b1;
        for (int i = 0; i < 2; i++) begin
            req[i] = 1'b0;
            din[i] = 8'h00;
            lat_armed[i] = 1'b0;
            burst_pos[i] = 0;
            req_t[i] = 0;
        end
        repeat (3) @(negedge clk);
        for (int i = 0; i < 2; i++) begin
            fail_chk({rdy[i], ser[i], en[i], hs[i], bsy[i], st[i]} === 14'h0,
                     $sformatf("reset_state%0d", i), {rdy[i], ser[i], en[i], hs[i], bsy[i], st[i]}, 0);
        end
        rst = 1'b0;
        mon_on = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 2; i++) begin
            pay_q = '{8'h12, 8'h34, 8'h56};
            send_burst(i, 1'b0);
            pay_q = '{8'h01, 8'h80};
            send_burst(i, 1'b0);
            pay_q = '{8'h7F};
            send_burst(i, 1'b0);
            pay_q.delete();
            send_burst(i, 1'b0);
            for (int r = 0; r < 6; r++) random_burst(i, 20);
            pay_q = '{8'hA5, 8'h5A, 8'hC3, 8'h3C};
            send_burst(i, 1'b0);
            pay_q.delete();
            for (int k = 0; k < 256; k++) pay_q.push_back(8'(k));
            send_burst(i, 1'b1);
        end

        wait_idle(0);
        wait_idle(1);
        repeat (3) @(negedge clk);
        fail_chk(exp_q0.size() == 0, "drain0", exp_q0.size(), 0);
        fail_chk(exp_q1.size() == 0, "drain1", exp_q1.size(), 0);

        // Reset in the middle of a payload stream must abort without any trail.
        mon_on = 1'b0;
        req[0] = 1'b1;
        din[0] = 8'h5C;
        b = 0;
        while (rdy[0] !== 1'b1 && b < 100) begin
            @(negedge clk);
            b++;
        end
        fail_chk(rdy[0] === 1'b1, "reach_data", rdy[0], 1);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        #1;
        fail_chk({rdy[0], ser[0], en[0], hs[0], bsy[0], st[0]} === 14'h0, "abort_outputs",
                 {rdy[0], ser[0], en[0], hs[0], bsy[0], st[0]}, 0);
        @(negedge clk);
        rst = 1'b0;
        req[0] = 1'b0;
        b = 0;
        for (int c = 0; c < 8; c++) begin
            if (en[0] || hs[0] || bsy[0]) b++;
            @(negedge clk);
        end
        fail_chk(b == 0, "no_trail_after_reset", b, 0);
        exp_q0.delete();
        lat_armed[0] = 1'b0;
        mon_on = 1'b1;

        pay_q = '{8'h11, 8'h22};
        send_burst(0, 1'b0);
        wait_idle(0);
        repeat (3) @(negedge clk);
        fail_chk(exp_q0.size() == 0, "drain_after_reset", exp_q0.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: got %0t expected completion", $time);
        $fatal(1, "global timeout");
    end

endmodule
